// File: rtl/mp3_pkg.sv
// Shared defaults and types for the audio sample fetch path.
// The fetcher and its sample FIFO both import this package.
package mp3_pkg;

   localparam int ADDR_W_DEF     = 26;
   localparam int SAMPLE_W_DEF   = 16;
   localparam int FIFO_DEPTH_DEF = 8;

   // 16-bit samples always use both byte lanes of the bridge
   localparam logic [1:0] BRIDGE_BE_ALL = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DONE = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with a registered read port and a synchronous flush.
// out_clear forces the read register to zero so the consumer sees silence on underrun.
module sample_fifo
   import mp3_pkg::*;
#(
   parameter int W     = SAMPLE_W_DEF,
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   input  logic                     out_clear,
   output logic [W-1:0]             pop_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [W-1:0]  pop_data_q, pop_data_d;
   logic          do_push;
   logic          do_pop;

   assign full     = (level_q == DEPTH_L);
   assign empty    = (level_q == '0);
   assign do_push  = push && !full && !flush;
   assign do_pop   = pop && !empty && !flush;
   assign level    = level_q;
   assign pop_data = pop_data_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      pop_data_d = pop_data_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
      // A simultaneous push into an empty FIFO is not forwarded here
      if (out_clear) begin
         pop_data_d = '0;
      end else if (do_pop) begin
         pop_data_d = mem[rd_ptr_q];
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         pop_data_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         pop_data_q <= pop_data_d;
      end
   end

endmodule

// File: rtl/sample_fetcher.sv
// Streams a track of audio samples from SDRAM over an Avalon bridge into a small FIFO
// and hands them to the I2S serializer one per sample_req pulse.
module sample_fetcher
   import mp3_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int SAMPLE_W   = SAMPLE_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                          MAX10_CLK1_50,
   input  logic                          Reset,
   input  logic                          play,
   input  logic [ADDR_W-1:0]             start_addr,
   input  logic [ADDR_W-1:0]             end_addr,
   output logic [ADDR_W-1:0]             bridge_address,
   output logic [1:0]                    bridge_byte_enable,
   output logic                          bridge_read,
   output logic                          bridge_write,
   input  logic                          bridge_acknowledge,
   input  logic [SAMPLE_W-1:0]           bridge_read_data,
   input  logic                          sample_req,
   output logic [SAMPLE_W-1:0]           sample_data,
   output logic                          underrun,
   output logic                          done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   fetch_state_t      state_q;
   logic [ADDR_W-1:0] cur_addr_q;
   logic [ADDR_W-1:0] bridge_address_q;
   logic              bridge_read_q;
   logic              done_q;
   logic              underrun_q, underrun_d;

   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_clear_out;

   // Data returned after play has dropped belongs to an abandoned track and is dropped
   assign fifo_push      = bridge_acknowledge && (state_q == READ) && play;
   assign fifo_pop       = sample_req && play && !fifo_empty;
   assign fifo_clear_out = sample_req && !fifo_pop;

   always_comb begin
      underrun_d = fifo_clear_out;
   end

   sample_fifo #(
      .W     (SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (MAX10_CLK1_50),
      .srst      (Reset),
      .flush     (!play),
      .push      (fifo_push),
      .push_data (bridge_read_data),
      .pop       (fifo_pop),
      .out_clear (fifo_clear_out),
      .pop_data  (sample_data),
      .level     (fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Fetch FSM: one read outstanding at most, so a full check in IDLE prevents overflow
   always_ff @(posedge MAX10_CLK1_50) begin
      if (Reset) begin
         state_q          <= IDLE;
         cur_addr_q       <= start_addr;
         bridge_address_q <= start_addr;
         bridge_read_q    <= 1'b0;
         done_q           <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!play) begin
                  cur_addr_q <= start_addr;
               end else if (!fifo_full) begin
                  state_q          <= READ;
                  bridge_read_q    <= 1'b1;
                  bridge_address_q <= cur_addr_q;
               end
            end
            READ: begin
               if (!play) begin
                  cur_addr_q <= start_addr;
               end
               if (bridge_acknowledge) begin
                  bridge_read_q <= 1'b0;
                  if (play && (cur_addr_q >= end_addr)) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     if (play) begin
                        cur_addr_q <= cur_addr_q + ADDR_W'(1);
                     end
                  end
               end
            end
            DONE: begin
               if (!play) begin
                  state_q    <= IDLE;
                  done_q     <= 1'b0;
                  cur_addr_q <= start_addr;
               end
            end
            default: begin
               state_q       <= IDLE;
               bridge_read_q <= 1'b0;
               done_q        <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge MAX10_CLK1_50) begin
      if (Reset) begin
         underrun_q <= 1'b0;
      end else begin
         underrun_q <= underrun_d;
      end
   end

   assign bridge_address     = bridge_address_q;
   assign bridge_read        = bridge_read_q;
   assign bridge_byte_enable = BRIDGE_BE_ALL;
   assign bridge_write       = 1'b0;
   assign done               = done_q;
   assign underrun           = underrun_q;

endmodule

// File: tb/tb_sample_fetcher.sv
// Scoreboard bench for sample_fetcher: expected read addresses and sample responses are
// queued by the stimulus and popped by independent monitors.
module tb_sample_fetcher;

   localparam int AW = 26;
   localparam int SW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          play;
   logic          sample_req;
   logic [AW-1:0] start_addr;
   logic [AW-1:0] end_addr;
   logic [AW-1:0] bridge_address;
   logic [1:0]    bridge_byte_enable;
   logic          bridge_read;
   logic          bridge_write;
   logic          bridge_acknowledge;
   logic [SW-1:0] bridge_read_data;
   logic [SW-1:0] sample_data;
   logic          underrun;
   logic          done;
   logic [3:0]    fifo_level;

   logic          auto_en;
   logic          ack_a;
   logic          ack_m;
   logic [SW-1:0] data_a;
   logic [SW-1:0] data_m;

   int            vectors = 0;
   int            miscompares = 0;
   logic [AW-1:0] exp_addr_q[$];
   logic [SW:0]   exp_smp_q[$];

   always #5 clk = ~clk;

   assign bridge_acknowledge = ack_a | ack_m;
   assign bridge_read_data   = ack_m ? data_m : data_a;

   sample_fetcher dut (
      .MAX10_CLK1_50      (clk),
      .Reset              (rst),
      .play               (play),
      .start_addr         (start_addr),
      .end_addr           (end_addr),
      .bridge_address     (bridge_address),
      .bridge_byte_enable (bridge_byte_enable),
      .bridge_read        (bridge_read),
      .bridge_write       (bridge_write),
      .bridge_acknowledge (bridge_acknowledge),
      .bridge_read_data   (bridge_read_data),
      .sample_req         (sample_req),
      .sample_data        (sample_data),
      .underrun           (underrun),
      .done               (done),
      .fifo_level         (fifo_level)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [SW-1:0] d, input logic u);
      exp_smp_q.push_back({u, d});
      sample_req = 1'b1;
      tick(1);
      sample_req = 1'b0;
   endtask

   task automatic wait_for_done(input int budget);
      for (int i = 0; i < budget && done !== 1'b1; i++) tick(1);
      check("done_reached", 32'(done), 1);
   endtask

   task automatic wait_for_read(input int budget);
      for (int i = 0; i < budget && bridge_read !== 1'b1; i++) tick(1);
      check("read_issued", 32'(bridge_read), 1);
   endtask

   task automatic wait_for_level(input logic [3:0] lvl, input int budget);
      for (int i = 0; i < budget && fifo_level !== lvl; i++) tick(1);
      check("level_reached", 32'(fifo_level), 32'(lvl));
   endtask

   // Memory model: word at address A reads as 0x5A00 | A[7:0], acked two cycles after the request
   initial begin : responder
      int cnt;
      cnt    = 0;
      ack_a  = 1'b0;
      data_a = '0;
      forever begin
         @(negedge clk);
         ack_a = 1'b0;
         if (auto_en && bridge_read) begin
            cnt++;
            if (cnt == 2) begin
               ack_a  = 1'b1;
               data_a = 16'h5A00 | {8'h00, bridge_address[7:0]};
               cnt    = 0;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   initial begin : addr_monitor
      logic          prev;
      logic [AW-1:0] held;
      prev = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (bridge_read && !prev) begin
            if (exp_addr_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_read: got read at 0x%0h, expected no read (t=%0t)", bridge_address, $time);
            end else begin
               check("read_addr", 32'(bridge_address), 32'(exp_addr_q.pop_front()));
            end
            held = bridge_address;
         end else if (bridge_read && prev) begin
            check("addr_stable", 32'(bridge_address), 32'(held));
         end
         prev = bridge_read;
      end
   end

   initial begin : sample_monitor
      logic        req_prev;
      logic [SW:0] e;
      req_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (req_prev) begin
            if (exp_smp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_sample: got data 0x%0h, expected no entry (t=%0t)", sample_data, $time);
            end else begin
               e = exp_smp_q.pop_front();
               check("sample_data", 32'(sample_data), 32'(e[SW-1:0]));
               check("underrun", 32'(underrun), 32'(e[SW]));
            end
         end else begin
            check("underrun_idle", 32'(underrun), 0);
         end
         req_prev = sample_req;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before 500000");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      rst        = 1'b1;
      play       = 1'b0;
      sample_req = 1'b0;
      ack_m      = 1'b0;
      data_m     = '0;
      auto_en    = 1'b1;
      start_addr = 26'h10;
      end_addr   = 26'h13;
      tick(3);
      check("rst_read", 32'(bridge_read), 0);
      check("rst_sample", 32'(sample_data), 0);
      check("rst_done", 32'(done), 0);
      check("rst_level", 32'(fifo_level), 0);
      check("byte_enable", 32'(bridge_byte_enable), 3);
      check("write_const", 32'(bridge_write), 0);

      // Four-word track, no consumer
      rst = 1'b0;
      tick(1);
      for (int a = 16; a <= 19; a++) exp_addr_q.push_back(AW'(a));
      play = 1'b1;
      wait_for_done(60);
      check("t1_level", 32'(fifo_level), 4);
      tick(5);
      check("t1_no_more_reads", 32'(bridge_read), 0);
      check("t1_addr_q_empty", 32'(exp_addr_q.size()), 0);
      req(16'h5A10, 1'b0);
      req(16'h5A11, 1'b0);
      req(16'h5A12, 1'b0);
      req(16'h5A13, 1'b0);
      req(16'h0000, 1'b1);
      tick(1);
      check("t1_drained", 32'(fifo_level), 0);
      check("t1_done_held", 32'(done), 1);
      play = 1'b0;
      tick(2);
      check("t1_done_clr", 32'(done), 0);

      // Fill to capacity, then one pop frees a slot for start+8
      start_addr = 26'h20;
      end_addr   = 26'h100;
      tick(1);
      for (int a = 32; a <= 39; a++) exp_addr_q.push_back(AW'(a));
      play = 1'b1;
      wait_for_level(4'd8, 100);
      tick(10);
      check("t2_full_no_read", 32'(bridge_read), 0);
      check("t2_full_level", 32'(fifo_level), 8);
      exp_addr_q.push_back(26'h28);
      req(16'h5A20, 1'b0);
      wait_for_level(4'd8, 20);
      check("t2_addr_q_empty", 32'(exp_addr_q.size()), 0);
      play = 1'b0;
      req(16'h0000, 1'b1);
      tick(1);
      check("t2_flushed", 32'(fifo_level), 0);

      // Underrun, then ack coinciding with a request
      auto_en    = 1'b0;
      start_addr = 26'h40;
      end_addr   = 26'h100;
      tick(1);
      exp_addr_q.push_back(26'h40);
      play = 1'b1;
      wait_for_read(10);
      req(16'h0000, 1'b1);
      check("t3_level_empty", 32'(fifo_level), 0);
      exp_addr_q.push_back(26'h41);
      exp_smp_q.push_back({1'b1, 16'h0000});
      sample_req = 1'b1;
      ack_m      = 1'b1;
      data_m     = 16'hBEEF;
      tick(1);
      sample_req = 1'b0;
      ack_m      = 1'b0;
      check("t3_level_one", 32'(fifo_level), 1);
      req(16'hBEEF, 1'b0);
      tick(1);
      check("t3_level_zero", 32'(fifo_level), 0);

      // play drops while the read at 0x41 is pending
      wait_for_read(10);
      play = 1'b0;
      tick(3);
      check("t4_read_held", 32'(bridge_read), 1);
      ack_m  = 1'b1;
      data_m = 16'h1234;
      tick(1);
      ack_m = 1'b0;
      tick(1);
      check("t4_discard_level", 32'(fifo_level), 0);
      check("t4_read_dropped", 32'(bridge_read), 0);
      end_addr = 26'h41;
      auto_en  = 1'b1;
      tick(1);
      exp_addr_q.push_back(26'h40);
      exp_addr_q.push_back(26'h41);
      play = 1'b1;
      wait_for_done(40);
      check("t4_level", 32'(fifo_level), 2);
      req(16'h5A40, 1'b0);
      req(16'h5A41, 1'b0);
      tick(1);
      check("t4_drained", 32'(fifo_level), 0);
      play = 1'b0;
      tick(2);

      // Reset in the middle of a read, stray ack afterwards
      auto_en    = 1'b0;
      start_addr = 26'h60;
      end_addr   = 26'h100;
      tick(1);
      exp_addr_q.push_back(26'h60);
      play = 1'b1;
      wait_for_read(10);
      tick(1);
      rst  = 1'b1;
      play = 1'b0;
      tick(1);
      check("t5_read_drop", 32'(bridge_read), 0);
      rst = 1'b0;
      tick(1);
      ack_m  = 1'b1;
      data_m = 16'hDEAD;
      tick(1);
      ack_m = 1'b0;
      tick(1);
      check("t5_level", 32'(fifo_level), 0);
      check("t5_read", 32'(bridge_read), 0);
      check("t5_done", 32'(done), 0);
      check("t5_sample", 32'(sample_data), 0);

      // end_addr below start_addr: one word only
      auto_en    = 1'b1;
      start_addr = 26'h08;
      end_addr   = 26'h05;
      tick(1);
      exp_addr_q.push_back(26'h08);
      play = 1'b1;
      wait_for_done(20);
      check("t6_level", 32'(fifo_level), 1);
      tick(4);
      check("t6_no_more_reads", 32'(bridge_read), 0);
      req(16'h5A08, 1'b0);
      tick(1);
      play = 1'b0;
      tick(2);
      check("t6_done_clr", 32'(done), 0);

      check("final_addr_q", 32'(exp_addr_q.size()), 0);
      check("final_smp_q", 32'(exp_smp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
